keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Behavioural stand-in for the 4x4 membrane keypad, driven from switch or bench events. It is the passive end of the keypad scan interface. It watches the `col` lines driven by the existing keypad decoder and pulls the matching `row` line low while an emulated key is held. Each accepted event is a key code that produces one timed press/release, with optional contact bounce. This lets the decoder and game logic run on boards and benches without a physical keypad.

## Interface
Parameters:
- `HOLD_CYCLES`, 24'd1_000_000: clock periods the contact is solidly closed; must be ≥1.
- `BOUNCE_CYCLES`, 24'd20_000: length of each bounce phase (press and release); must be ≥1.
- `BOUNCE_PERIOD`, 24'd2_500: contact toggle interval inside a bounce phase; must be ≥1 and ≤ `BOUNCE_CYCLES`.
- `GAP_CYCLES`, 24'd500_000: released time before the next event is accepted; must be ≥1.
- `CNT_W`, 24: width of the shared duration counter.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ev_valid` in 1: key event offered.
- `ev_ready` out 1: block can accept an event.
- `ev_key` in 4: hex key code, 0x0–0xF.
- `ev_bounce` in 1: sampled with the event; 1 adds bounce phases.
- `col` in 4: column drive from the decoder, active-low.
- `row` out 4: row sense to the decoder, active-low, idle 4'b1111.
- `busy` out 1: an event is in progress (any state but IDLE).
- `contact` out 1: present emulated contact state.
- `active_key` out 4: latched key code of the current event.

## Operation
- Key map, where (r,c) means `row[3-r]`, `col[3-c]`:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Row output: `row` = 4'b1111, except that the mapped row bit is 0 when `contact`=1 and the mapped `col` bit = 0.
  - This path is combinational from registered state and the live `col`, modelling a passive switch.
  - Other col bits low have no effect.
  - All cols low with `contact`=1 gives exactly one row bit low.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- Accept: when `ev_valid`&&`ev_ready`, latch `ev_key` and `ev_bounce`, load the counter, and go to BOUNCE_IN if bounce is set, else HOLD.
- BOUNCE_IN: contact starts closed and toggles every `BOUNCE_PERIOD` cycles. After `BOUNCE_CYCLES` → HOLD.
- HOLD: contact=1 for `HOLD_CYCLES`, then → BOUNCE_OUT if bounce is set, else GAP.
- BOUNCE_OUT: contact starts open and toggles every `BOUNCE_PERIOD`. After `BOUNCE_CYCLES` → GAP.
- GAP: contact=0 for `GAP_CYCLES`, then → IDLE.
- Input changes during an event: `ev_key`/`ev_bounce` changes after accept are ignored. `ev_valid` held while `ev_ready`=0 has no effect, and nothing is queued.
- Counter: a single down-counter, `CNT_W` bits, reloaded on every state entry. A separate toggle counter is used in the bounce states. Neither counter wraps; both reload at 0.

## Timing
- Reset values:
  - state IDLE
  - `ev_ready`=0
  - `busy`=0
  - `contact`=0
  - `active_key`=0
  - `row`=4'b1111 regardless of `col`
- `ev_ready` is registered. It rises on the first edge with `rst_n`=1 while in IDLE and falls on the accept edge.
- No-bounce event accepted at edge 0:
  - `contact`=1 from edge 0 for exactly `HOLD_CYCLES` periods.
  - `contact`=0 from edge `HOLD_CYCLES`.
  - `ev_ready`=1 from edge `HOLD_CYCLES`+`GAP_CYCLES`.
- Bounce event: total busy time is 2·`BOUNCE_CYCLES`+`HOLD_CYCLES`+`GAP_CYCLES` periods.
- Back-to-back events: minimum spacing between accepts equals the busy time above. `busy` is 0 in the cycle `ev_ready` is 1.
- Reset mid-event: on the edge with `rst_n`=0, return to IDLE with `contact`=0. `row` reads 4'b1111 from that edge onward.
- `row` responds to a `col` change within the same cycle, with zero clock latency.

## Structure
- `keypad_pkg` holds:
  - the state enum
  - the key→(row,col) map as a function/constant table
  - `ROW_IDLE`=4'b1111
  - active-low polarity constants
- Sub-module `keypad_key_map` is combinational: `ev_key` in, one-hot active-low row mask and col index out. It is shared with future keypad-side blocks.
- The FSM and counters live in `keypad_emulator`.

## Test plan
- Reset hold (`col` swept through all 16 values) → `row`=4'b1111, `ev_ready`=0. Release reset → `ev_ready`=1 one edge later.
- HOLD=8, GAP=4, key 0x5, no bounce; `col`=4'b1011 → `row`=4'b1011 for exactly 8 cycles. `col`=4'b0111 → `row`=4'b1111. `ev_ready` returns at cycle 12.
- Key 0xD with `col`=4'b0000 → `row`=4'b1110. Key 0x1 → `row`=4'b0111.
- Bounce on, BOUNCE_CYCLES=6, PERIOD=2 → `contact` reads 1,1,0,0,1,1 then solid 1 for HOLD; release reads 0,0,1,1,0,0. Busy time is 12+HOLD+GAP.
- `ev_valid` held high with keys 0x3 then 0xA → exactly two presses, with the second accepted on the first `ev_ready` cycle after the gap. A key change mid-event does not alter `row`.
- `rst_n` pulsed low during HOLD → `row`=4'b1111 and `busy`=0 on the reset edge. A new event is accepted after `ev_ready` rises.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, line polarity and the key -> (row, col) map
// used by the keypad emulator and any future keypad-side blocks.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNCE_IN,
    ST_HOLD,
    ST_BOUNCE_OUT,
    ST_GAP
  } state_e;

  // Matrix position: r selects row[3-r], c selects col[3-c].
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_pos_t;

  localparam logic [3:0] ROW_IDLE    = 4'b1111;
  localparam logic       LINE_ACTIVE = 1'b0;
  localparam logic       LINE_IDLE   = 1'b1;

  function automatic key_pos_t key_pos(input logic [3:0] key);
    key_pos_t p;
    p = '{2'd3, 2'd0};
    case (key)
      4'h1: p = '{2'd0, 2'd0};
      4'h2: p = '{2'd0, 2'd1};
      4'h3: p = '{2'd0, 2'd2};
      4'hA: p = '{2'd0, 2'd3};
      4'h4: p = '{2'd1, 2'd0};
      4'h5: p = '{2'd1, 2'd1};
      4'h6: p = '{2'd1, 2'd2};
      4'hB: p = '{2'd1, 2'd3};
      4'h7: p = '{2'd2, 2'd0};
      4'h8: p = '{2'd2, 2'd1};
      4'h9: p = '{2'd2, 2'd2};
      4'hC: p = '{2'd2, 2'd3};
      4'h0: p = '{2'd3, 2'd0};
      4'hF: p = '{2'd3, 2'd1};
      4'hE: p = '{2'd3, 2'd2};
      4'hD: p = '{2'd3, 2'd3};
      default: p = '{2'd3, 2'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Key-event handshake into the keypad emulator: valid/ready plus the key code
// and the bounce request sampled with it.
interface keypad_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_key;
  logic       ev_bounce;

  modport master (output ev_valid, ev_key, ev_bounce, input ev_ready);
  modport slave  (input ev_valid, ev_key, ev_bounce, output ev_ready);
endinterface

// File: rtl/keypad_key_map.sv
// Combinational key decode: key code to active-low one-hot row mask and the
// bit index of the col line that key sits on.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] ev_key,
  output logic [3:0] row_mask,
  output logic [1:0] col_idx
);

  key_pos_t pos;

  always_comb begin
    pos                  = key_pos(ev_key);
    row_mask             = ROW_IDLE;
    row_mask[2'd3 - pos.r] = LINE_ACTIVE;
    col_idx              = 2'd3 - pos.c;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad stand-in: each accepted key event becomes one timed
// press/release (optionally bounced) seen by the scanning decoder on row.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned      CNT_W         = 24,
  parameter logic [CNT_W-1:0] HOLD_CYCLES   = 24'd1_000_000,
  parameter logic [CNT_W-1:0] BOUNCE_CYCLES = 24'd20_000,
  parameter logic [CNT_W-1:0] BOUNCE_PERIOD = 24'd2_500,
  parameter logic [CNT_W-1:0] GAP_CYCLES    = 24'd500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  keypad_if.slave    ev,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       contact,
  output logic [3:0] active_key
);

  // Counters hold "cycles remaining minus one" so a phase ends when they read zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD   = HOLD_CYCLES   - CNT_W'(1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = BOUNCE_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = BOUNCE_PERIOD - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = GAP_CYCLES    - CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             contact_q, contact_d;
  logic             ready_q, ready_d;
  logic             bounce_q, bounce_d;
  logic [3:0]       key_q, key_d;
  logic [3:0]       row_mask;
  logic [1:0]       col_idx;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    contact_d = contact_q;
    bounce_d  = bounce_q;
    key_d     = key_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ev.ev_valid && ready_q) begin
          key_d     = ev.ev_key;
          bounce_d  = ev.ev_bounce;
          contact_d = 1'b1;
          tcnt_d    = PERIOD_LOAD;
          if (ev.ev_bounce) begin
            state_d = ST_BOUNCE_IN;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
      end

      ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
        if (cnt_q == '0) begin
          if (state_q == ST_BOUNCE_IN) begin
            state_d   = ST_HOLD;
            cnt_d     = HOLD_LOAD;
            contact_d = 1'b1;
          end else begin
            state_d   = ST_GAP;
            cnt_d     = GAP_LOAD;
            contact_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (tcnt_q == '0) begin
            contact_d = ~contact_q;
            tcnt_d    = PERIOD_LOAD;
          end else begin
            tcnt_d = tcnt_q - CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          contact_d = 1'b0;
          tcnt_d    = PERIOD_LOAD;
          if (bounce_q) begin
            state_d = ST_BOUNCE_OUT;
            cnt_d   = BOUNCE_LOAD;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered ready lines up with the return to IDLE, so busy and ready never overlap.
    ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      contact_q <= 1'b0;
      ready_q   <= 1'b0;
      bounce_q  <= 1'b0;
      key_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      contact_q <= contact_d;
      ready_q   <= ready_d;
      bounce_q  <= bounce_d;
      key_q     <= key_d;
    end
  end

  keypad_key_map u_key_map (
    .ev_key   (key_q),
    .row_mask (row_mask),
    .col_idx  (col_idx)
  );

  // Passive switch: row follows the live col with no clock latency.
  always_comb begin
    row = ROW_IDLE;
    if (contact_q && (col[col_idx] == LINE_ACTIVE)) row = row_mask;
  end

  assign ev.ev_ready  = ready_q;
  assign busy         = (state_q != ST_IDLE);
  assign contact      = contact_q;
  assign active_key   = key_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with short timing parameters
// (HOLD=8, GAP=4, BOUNCE=6, PERIOD=2).
module tb_keypad_emulator;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       contact;
  logic [3:0] active_key;

  int n_cmp = 0;
  int n_err = 0;

  keypad_if ev_if ();

  keypad_emulator #(
    .CNT_W         (24),
    .HOLD_CYCLES   (24'd8),
    .BOUNCE_CYCLES (24'd6),
    .BOUNCE_PERIOD (24'd2),
    .GAP_CYCLES    (24'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev         (ev_if),
    .col        (col),
    .row        (row),
    .busy       (busy),
    .contact    (contact),
    .active_key (active_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (ev_if.ev_ready !== 1'b1 && n < max_cycles) begin
      tick(1);
      n++;
    end
    check(tag, 8'(ev_if.ev_ready), 8'h1);
  endtask

  task automatic send(input logic [3:0] key, input logic bounce);
    ev_if.ev_key    = key;
    ev_if.ev_bounce = bounce;
    ev_if.ev_valid  = 1'b1;
    tick(1);
    ev_if.ev_valid  = 1'b0;
  endtask

  initial begin
    logic [0:23] exp_c;

    rst_n           = 1'b0;
    col             = 4'b1111;
    ev_if.ev_valid  = 1'b0;
    ev_if.ev_key    = 4'h0;
    ev_if.ev_bounce = 1'b0;

    // Reset hold with col swept through every value.
    tick(2);
    for (int i = 0; i < 16; i++) begin
      col = 4'(i);
      tick(1);
      check($sformatf("rst_row[%0d]", i), 8'(row), 8'hF);
    end
    check("rst_ready", 8'(ev_if.ev_ready), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_contact", 8'(contact), 8'h0);
    check("rst_key", 8'(active_key), 8'h0);
    rst_n = 1'b1;
    tick(1);
    check("ready_after_rst", 8'(ev_if.ev_ready), 8'h1);
    check("idle_busy", 8'(busy), 8'h0);

    // Key 5, no bounce: exactly 8 cycles of contact, ready back at cycle 12.
    col = 4'b1011;
    send(4'h5, 1'b0);
    check("k5_key", 8'(active_key), 8'h5);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("k5_row[%0d]", k), 8'(row), 8'hB);
      check($sformatf("k5_contact[%0d]", k), 8'(contact), 8'h1);
      check($sformatf("k5_ready[%0d]", k), 8'(ev_if.ev_ready), 8'h0);
      if (k == 3) begin
        col = 4'b0111;
        #1;
        check("k5_other_col", 8'(row), 8'hF);
        col = 4'b1011;
        #1;
      end
      tick(1);
    end
    check("k5_release_contact", 8'(contact), 8'h0);
    check("k5_release_row", 8'(row), 8'hF);
    for (int k = 8; k < 12; k++) begin
      check($sformatf("k5_gap_ready[%0d]", k), 8'(ev_if.ev_ready), 8'h0);
      check($sformatf("k5_gap_busy[%0d]", k), 8'(busy), 8'h1);
      tick(1);
    end
    check("k5_ready_12", 8'(ev_if.ev_ready), 8'h1);
    check("k5_busy_12", 8'(busy), 8'h0);

    // Corner keys with every col driven low.
    col = 4'b0000;
    send(4'hD, 1'b0);
    check("kD_row", 8'(row), 8'hE);
    check("kD_key", 8'(active_key), 8'hD);
    wait_ready("kD_done", 40);
    send(4'h1, 1'b0);
    check("k1_row", 8'(row), 8'h7);
    col = 4'b1111;
    #1;
    check("k1_no_col", 8'(row), 8'hF);
    col = 4'b0000;
    wait_ready("k1_done", 40);

    // Bounced key 6: 1,1,0,0,1,1 / hold / 0,0,1,1,0,0 / gap, busy 24 cycles.
    exp_c = 24'b110011_11111111_001100_0000;
    send(4'h6, 1'b1);
    for (int e = 0; e < 24; e++) begin
      check($sformatf("b6_contact[%0d]", e), 8'(contact), 8'(exp_c[e]));
      check($sformatf("b6_row[%0d]", e), 8'(row), exp_c[e] ? 8'hB : 8'hF);
      check($sformatf("b6_busy[%0d]", e), 8'(busy), 8'h1);
      if (e == 3) begin
        ev_if.ev_key    = 4'h1;
        ev_if.ev_bounce = 1'b0;
      end
      if (e == 10) check("b6_key_kept", 8'(active_key), 8'h6);
      tick(1);
    end
    check("b6_ready_24", 8'(ev_if.ev_ready), 8'h1);
    check("b6_busy_24", 8'(busy), 8'h0);

    // ev_valid held through two events: keys 3 then A, nothing queued.
    col             = 4'b1101;
    ev_if.ev_key    = 4'h3;
    ev_if.ev_bounce = 1'b0;
    ev_if.ev_valid  = 1'b1;
    tick(1);
    check("k3_key", 8'(active_key), 8'h3);
    check("k3_row", 8'(row), 8'h7);
    ev_if.ev_key = 4'hA;
    tick(4);
    check("k3_row_kept", 8'(row), 8'h7);
    check("k3_key_kept", 8'(active_key), 8'h3);
    tick(8);
    check("k3_ready_12", 8'(ev_if.ev_ready), 8'h1);
    check("k3_busy_12", 8'(busy), 8'h0);
    tick(1);
    check("kA_busy", 8'(busy), 8'h1);
    check("kA_ready", 8'(ev_if.ev_ready), 8'h0);
    check("kA_key", 8'(active_key), 8'hA);
    check("kA_contact", 8'(contact), 8'h1);
    ev_if.ev_valid = 1'b0;
    col = 4'b1110;
    #1;
    check("kA_row", 8'(row), 8'h7);
    col = 4'b1101;
    #1;
    check("kA_wrong_col", 8'(row), 8'hF);
    tick(11);
    check("kA_ready_11", 8'(ev_if.ev_ready), 8'h0);
    check("kA_busy_11", 8'(busy), 8'h1);
    tick(1);
    check("kA_ready_12", 8'(ev_if.ev_ready), 8'h1);
    tick(3);
    check("no_third_busy", 8'(busy), 8'h0);
    check("no_third_ready", 8'(ev_if.ev_ready), 8'h1);

    // Reset pulsed during HOLD, then a fresh event.
    col = 4'b1011;
    send(4'h5, 1'b0);
    tick(3);
    check("mid_contact", 8'(contact), 8'h1);
    check("mid_row", 8'(row), 8'hB);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_row", 8'(row), 8'hF);
    check("mid_rst_busy", 8'(busy), 8'h0);
    check("mid_rst_contact", 8'(contact), 8'h0);
    check("mid_rst_ready", 8'(ev_if.ev_ready), 8'h0);
    col = 4'b0000;
    #1;
    check("mid_rst_row_col0", 8'(row), 8'hF);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_ready", 8'(ev_if.ev_ready), 8'h1);
    col = 4'b1101;
    send(4'hE, 1'b0);
    check("kE_row", 8'(row), 8'hE);
    check("kE_key", 8'(active_key), 8'hE);
    wait_ready("kE_done", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
